// File: rtl/scr1_dmem_wbuf_pkg.sv
// Memory-interface types and defaults shared by the data-memory write buffer.
// The SCR1_DMEM_WBUF_ERRRESP_EN build option affects only scr1_dmem_wbuf.sv.
package scr1_dmem_wbuf_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef struct packed {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [31:0]          addr;
        logic [31:0]          wdata;
    } type_scr1_wbuf_entry_s;

    localparam int SCR1_WBUF_DEPTH_DFLT = 4;
    localparam int SCR1_WBUF_OUTST_DFLT = 2;
    localparam int SCR1_WBUF_ENTRY_W    = $bits(type_scr1_wbuf_entry_s);

endpackage

// File: rtl/scr1_dmem_wbuf_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two, at least 2.
// Pointers wrap naturally, so full/empty are taken from the count.
module scr1_wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_r;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_r == CW'(DEPTH));
    assign empty   = (cnt_r == '0);
    assign cnt     = cnt_r;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_r  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt_r <= cnt_r + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/scr1_dmem_wbuf.sv
// Posted-write buffer between the LSU data port and the data-memory bridge.
// Define SCR1_DMEM_WBUF_ERRRESP_EN to report a posted-write error on the next load.
module scr1_dmem_wbuf
    import scr1_dmem_wbuf_pkg::*;
#(
    parameter int SCR1_WBUF_DEPTH = SCR1_WBUF_DEPTH_DFLT,
    parameter int SCR1_WBUF_OUTST = SCR1_WBUF_OUTST_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 core_req_ack,
    input  logic                 core_req,
    input  type_scr1_mem_cmd_e   core_cmd,
    input  type_scr1_mem_width_e core_width,
    input  logic [31:0]          core_addr,
    input  logic [31:0]          core_wdata,
    output logic [31:0]          core_rdata,
    output type_scr1_mem_resp_e  core_resp,
    input  logic                 mem_req_ack,
    output logic                 mem_req,
    output type_scr1_mem_cmd_e   mem_cmd,
    output type_scr1_mem_width_e mem_width,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  type_scr1_mem_resp_e  mem_resp,
    output logic                 wbuf_idle,
    output logic                 wbuf_wr_err
);

    localparam int RCW = $clog2(SCR1_WBUF_DEPTH) + 1;
    localparam int OCW = $clog2(SCR1_WBUF_OUTST) + 1;
    localparam logic [OCW-1:0] OUTST_MAX = OCW'(SCR1_WBUF_OUTST);

    type_scr1_wbuf_entry_s         push_entry;
    type_scr1_wbuf_entry_s         head;
    logic [SCR1_WBUF_ENTRY_W-1:0]  head_bits;
    logic                          req_full;
    logic                          req_empty;
    logic [RCW-1:0]                req_cnt;
    logic                          push;
    logic                          pop;

    logic                          tag_din;
    logic                          tag_dout;
    logic                          tag_full;
    logic                          tag_empty;
    logic [OCW-1:0]                outst_cnt;
    logic                          tag_pop;
    logic                          rd_resp;
    logic                          wr_resp;

    logic                          rd_pend;
    logic                          wr_ack_r;
    logic                          unused_sig;

    assign push_entry   = '{cmd: core_cmd, width: core_width, addr: core_addr, wdata: core_wdata};
    assign head         = type_scr1_wbuf_entry_s'(head_bits);
    assign core_req_ack = ~req_full & ~rd_pend;
    assign push         = core_req & core_req_ack;

    assign mem_req   = ~req_empty & (outst_cnt < OUTST_MAX);
    assign mem_cmd   = head.cmd;
    assign mem_width = head.width;
    assign mem_addr  = head.addr;
    assign mem_wdata = head.wdata;
    assign pop       = mem_req & mem_req_ack;

    // The tag FIFO occupancy is the number of accepted-but-unanswered requests.
    assign tag_din   = head.cmd;
    assign tag_pop   = (mem_resp != SCR1_MEM_RESP_NOTRDY) & ~tag_empty;
    assign rd_resp   = tag_pop & (tag_dout == SCR1_MEM_CMD_RD);
    assign wr_resp   = tag_pop & (tag_dout == SCR1_MEM_CMD_WR);
    assign wbuf_idle = req_empty & (outst_cnt == '0);

    assign unused_sig = ^{req_cnt, tag_full};

    scr1_wbuf_fifo #(
        .DEPTH (SCR1_WBUF_DEPTH),
        .WIDTH (SCR1_WBUF_ENTRY_W)
    ) i_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_bits),
        .full  (req_full),
        .empty (req_empty),
        .cnt   (req_cnt)
    );

    scr1_wbuf_fifo #(
        .DEPTH (SCR1_WBUF_OUTST),
        .WIDTH (1)
    ) i_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pop),
        .din   (tag_din),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .cnt   (outst_cnt)
    );

    always_comb begin
        core_resp  = SCR1_MEM_RESP_NOTRDY;
        core_rdata = '0;
        if (rd_resp) begin
            core_resp  = mem_resp;
            core_rdata = mem_rdata;
`ifdef SCR1_DMEM_WBUF_ERRRESP_EN
            if (wbuf_wr_err) begin
                core_resp = SCR1_MEM_RESP_RDY_ER;
            end
`endif
        end else if (wr_ack_r) begin
            core_resp = SCR1_MEM_RESP_RDY_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend     <= 1'b0;
            wr_ack_r    <= 1'b0;
            wbuf_wr_err <= 1'b0;
        end else begin
            wr_ack_r <= push & (core_cmd == SCR1_MEM_CMD_WR);
            if (push & (core_cmd == SCR1_MEM_CMD_RD)) begin
                rd_pend <= 1'b1;
            end else if (rd_resp) begin
                rd_pend <= 1'b0;
            end
            if (wr_resp & (mem_resp == SCR1_MEM_RESP_RDY_ER)) begin
                wbuf_wr_err <= 1'b1;
            end
`ifdef SCR1_DMEM_WBUF_ERRRESP_EN
            else if (rd_resp) begin
                wbuf_wr_err <= 1'b0;
            end
`endif
        end
    end

    // A response with nothing outstanding means the bridge broke protocol.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (rst)
        (mem_resp != SCR1_MEM_RESP_NOTRDY) |-> !tag_empty);

endmodule

// File: tb/tb_scr1_dmem_wbuf.sv
// Directed bench for scr1_dmem_wbuf: per-cycle vector table plus hand-written
// sequences for FIFO-full release and mid-operation reset.
module tb_scr1_dmem_wbuf;
    import scr1_dmem_wbuf_pkg::*;

    localparam type_scr1_mem_resp_e NR = SCR1_MEM_RESP_NOTRDY;
    localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;
`ifdef SCR1_DMEM_WBUF_ERRRESP_EN
    localparam type_scr1_mem_resp_e ERR_LOAD_RESP = ER;
    localparam logic                ERR_AFTER     = 1'b0;
`else
    localparam type_scr1_mem_resp_e ERR_LOAD_RESP = OK;
    localparam logic                ERR_AFTER     = 1'b1;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 core_req_ack;
    logic                 core_req;
    type_scr1_mem_cmd_e   core_cmd;
    type_scr1_mem_width_e core_width;
    logic [31:0]          core_addr;
    logic [31:0]          core_wdata;
    logic [31:0]          core_rdata;
    type_scr1_mem_resp_e  core_resp;
    logic                 mem_req_ack;
    logic                 mem_req;
    type_scr1_mem_cmd_e   mem_cmd;
    type_scr1_mem_width_e mem_width;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    type_scr1_mem_resp_e  mem_resp;
    logic                 wbuf_idle;
    logic                 wbuf_wr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scr1_dmem_wbuf dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_ack (core_req_ack),
        .core_req     (core_req),
        .core_cmd     (core_cmd),
        .core_width   (core_width),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .core_resp    (core_resp),
        .mem_req_ack  (mem_req_ack),
        .mem_req      (mem_req),
        .mem_cmd      (mem_cmd),
        .mem_width    (mem_width),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .wbuf_idle    (wbuf_idle),
        .wbuf_wr_err  (wbuf_wr_err)
    );

    typedef struct {
        logic                rq;
        logic                wr;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic                mack;
        type_scr1_mem_resp_e mresp;
        logic [31:0]         mrdata;
        logic                e_ack;
        type_scr1_mem_resp_e e_resp;
        logic [31:0]         e_rdata;
        logic                e_mreq;
        logic [31:0]         e_maddr;
        logic [31:0]         e_mwdata;
        logic                e_idle;
        logic                e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rq, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic mack, type_scr1_mem_resp_e mresp, logic [31:0] mrdata,
                                logic e_ack, type_scr1_mem_resp_e e_resp, logic [31:0] e_rdata,
                                logic e_mreq, logic [31:0] e_maddr, logic [31:0] e_mwdata,
                                logic e_idle, logic e_err);
        vec_t v;
        v.rq = rq; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.mack = mack; v.mresp = mresp; v.mrdata = mrdata;
        v.e_ack = e_ack; v.e_resp = e_resp; v.e_rdata = e_rdata;
        v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_idle = e_idle; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        core_req    = 1'b0;
        core_cmd    = SCR1_MEM_CMD_RD;
        core_width  = SCR1_MEM_WIDTH_WORD;
        core_addr   = '0;
        core_wdata  = '0;
        mem_req_ack = 1'b0;
        mem_resp    = NR;
        mem_rdata   = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        core_req    = v.rq;
        core_cmd    = v.wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        core_addr   = v.addr;
        core_wdata  = v.wdata;
        mem_req_ack = v.mack;
        mem_resp    = v.mresp;
        mem_rdata   = v.mrdata;
        @(negedge clk);
        chk($sformatf("v%0d core_req_ack", idx), 32'(core_req_ack), 32'(v.e_ack));
        chk($sformatf("v%0d core_resp", idx), 32'(core_resp), 32'(v.e_resp));
        chk($sformatf("v%0d core_rdata", idx), core_rdata, v.e_rdata);
        chk($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.e_mreq));
        if (v.e_mreq) begin
            chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_mwdata);
        end
        chk($sformatf("v%0d wbuf_idle", idx), 32'(wbuf_idle), 32'(v.e_idle));
        chk($sformatf("v%0d wbuf_wr_err", idx), 32'(wbuf_wr_err), 32'(v.e_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rq wr addr     wdata        mk resp mrdata        ack resp rdata         mreq maddr    mwdata       idle err
        // single posted write, memory answers two cycles after accept
        vecs.push_back(mk(1, 1, 'h100, 'hDEADBEEF, 1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, OK, 0,            1, 'h100, 'hDEADBEEF,  0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 'h55,         1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        // write A, write B, read C; write D is held off until C returns
        vecs.push_back(mk(1, 1, 'h200, 'h11,       1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        vecs.push_back(mk(1, 1, 'h204, 'h22,       1, NR, 0,            1, OK, 0,            1, 'h200, 'h11,        0, 0));
        vecs.push_back(mk(1, 0, 'h300, 0,          1, NR, 0,            1, OK, 0,            1, 'h204, 'h22,        0, 0));
        vecs.push_back(mk(1, 1, 'h400, 'h44,       1, OK, 'h99,         0, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(1, 1, 'h400, 'h44,       1, OK, 'h98,         0, NR, 0,            1, 'h300, 0,           0, 0));
        vecs.push_back(mk(1, 1, 'h400, 'h44,       1, NR, 0,            0, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(1, 1, 'h400, 'h44,       1, OK, 'hCAFEF00D,   0, OK, 'hCAFEF00D,   0, 0,     0,           0, 0));
        vecs.push_back(mk(1, 1, 'h400, 'h44,       1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, OK, 0,            1, 'h400, 'h44,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        // three queued writes; outstanding limit stalls issue until a response
        vecs.push_back(mk(1, 1, 'h500, 'hA1,       0, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        vecs.push_back(mk(1, 1, 'h504, 'hA2,       0, NR, 0,            1, OK, 0,            1, 'h500, 'hA1,        0, 0));
        vecs.push_back(mk(1, 1, 'h508, 'hA3,       0, NR, 0,            1, OK, 0,            1, 'h500, 'hA1,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, OK, 0,            1, 'h500, 'hA1,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            1, 'h504, 'hA2,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            1, 'h508, 'hA3,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 0,            1, NR, 0,            0, 0,     0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        // posted write answered with RDY_ER, then a load answered RDY_OK
        vecs.push_back(mk(1, 1, 'h600, 'h55,       1, NR, 0,            1, NR, 0,            0, 0,     0,           1, 0));
        vecs.push_back(mk(1, 0, 'h604, 0,          1, NR, 0,            1, OK, 0,            1, 'h600, 'h55,        0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, ER, 0,            0, NR, 0,            1, 'h604, 0,           0, 0));
        vecs.push_back(mk(0, 0, 0,     0,          1, OK, 'h12345678,   0, ERR_LOAD_RESP, 'h12345678, 0, 0, 0,    0, 1));
        vecs.push_back(mk(0, 0, 0,     0,          1, NR, 0,            1, NR, 0,            0, 0,     0,           1, ERR_AFTER));

        do_reset();
        @(negedge clk);
        chk("reset core_req_ack", 32'(core_req_ack), 32'(1));
        chk("reset core_resp", 32'(core_resp), 32'(NR));
        chk("reset core_rdata", core_rdata, 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'(0));
        chk("reset wbuf_idle", 32'(wbuf_idle), 32'(1));
        chk("reset wbuf_wr_err", 32'(wbuf_wr_err), 32'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Five writes into a four-entry buffer with the bridge stalled.
        begin
            logic [31:0] got[$];
            int          pend;
            bit          acc5;
            do_reset();
            core_cmd = SCR1_MEM_CMD_WR;
            for (int i = 0; i < 4; i++) begin
                core_req   = 1'b1;
                core_addr  = 32'h700 + 32'(4 * i);
                core_wdata = 32'(i + 1);
                @(negedge clk);
                chk($sformatf("fill%0d core_req_ack", i), 32'(core_req_ack), 32'(1));
                @(posedge clk);
                #1;
            end
            core_addr  = 32'h710;
            core_wdata = 32'd5;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk($sformatf("full%0d core_req_ack", i), 32'(core_req_ack), 32'(0));
                chk($sformatf("full%0d mem_addr", i), mem_addr, 32'h700);
                @(posedge clk);
                #1;
            end
            mem_req_ack = 1'b1;
            pend = 0;
            acc5 = 1'b0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                mem_resp = (pend > 0) ? OK : NR;
                @(negedge clk);
                if (!acc5) begin
                    chk($sformatf("drain%0d w5 core_req_ack", cyc), 32'(core_req_ack),
                        32'(got.size() >= 1));
                    if (core_req_ack) acc5 = 1'b1;
                end
                if (pend > 0) pend--;
                if (mem_req) begin
                    got.push_back(mem_addr);
                    pend++;
                end
                @(posedge clk);
                #1;
                if (acc5) core_req = 1'b0;
                if (got.size() == 5 && pend == 0) break;
            end
            mem_resp = NR;
            chk("drain pop count", 32'(got.size()), 32'd5);
            for (int i = 0; i < got.size() && i < 5; i++) begin
                chk($sformatf("drain order %0d", i), got[i], 32'h700 + 32'(4 * i));
            end
            @(negedge clk);
            chk("drain wbuf_idle", 32'(wbuf_idle), 32'(1));
            @(posedge clk);
            #1;
        end

        // Reset with three writes buffered and the bridge stalled.
        do_reset();
        core_cmd = SCR1_MEM_CMD_WR;
        for (int i = 0; i < 3; i++) begin
            core_req   = 1'b1;
            core_addr  = 32'h800 + 32'(4 * i);
            core_wdata = 32'(i);
            @(posedge clk);
            #1;
        end
        core_req = 1'b0;
        @(negedge clk);
        chk("pre-rst wbuf_idle", 32'(wbuf_idle), 32'(0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst wbuf_idle", 32'(wbuf_idle), 32'(1));
        chk("rst mem_req", 32'(mem_req), 32'(0));
        chk("rst core_resp", 32'(core_resp), 32'(NR));
        chk("rst core_req_ack", 32'(core_req_ack), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scr1_dmem_wbuf.md
Name: scr1_dmem_wbuf

Overview:
- Posted-write buffer between the core LSU data port and the data memory AHB bridge.
- Core and memory sides both use the scr1 memif protocol:
  - A request is accepted when req and req_ack are high in the same cycle.
  - Exactly one in-order response (RDY_OK or RDY_ER) is returned per accepted request; NOTRDY otherwise.
- Writes are acknowledged to the core immediately and drained in order.
- Reads wait behind buffered writes, which preserves program order.

Parameters:
- SCR1_WBUF_DEPTH, 4: request FIFO entries; power of 2, at least 2.
- SCR1_WBUF_OUTST, 2: maximum accepted-but-unanswered requests on the memory side; matches the bridge.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- core_req_ack  out  1  request accepted this cycle
- core_req  in  1  request valid
- core_cmd  in  type_scr1_mem_cmd_e  RD/WR
- core_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- core_addr  in  32  byte address
- core_wdata  in  32  write data, LSB-aligned
- core_rdata  out  32  read data
- core_resp  out  type_scr1_mem_resp_e  response
- mem_req_ack  in  1  bridge accepted request
- mem_req  out  1  request valid
- mem_cmd  out  type_scr1_mem_cmd_e
- mem_width  out  type_scr1_mem_width_e
- mem_addr  out  32
- mem_wdata  out  32
- mem_rdata  in  32
- mem_resp  in  type_scr1_mem_resp_e
- wbuf_idle  out  1  request FIFO empty and no memory-side request outstanding; used for fence
- wbuf_wr_err  out  1  sticky: a posted write returned RDY_ER

Behaviour:
- Reset values: all FIFO counts 0; rd_pend=0; wr_ack_r=0; wbuf_wr_err=0; core_resp=NOTRDY; mem_req=0; wbuf_idle=1; core_rdata=0.
- Request FIFO:
  - Entry is {cmd, width, addr, wdata}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- core_req_ack = ~full & ~rd_pend.
  - Based on registered count only; no same-cycle pop-through when full.
- Push on core_req & core_req_ack.
  - The new entry is visible on the mem_* outputs the next cycle (1-cycle latency).
- Write accept sets wr_ack_r for one cycle: core_resp=RDY_OK in the cycle after acceptance (posted).
- Read accept sets rd_pend.
  - rd_pend clears in the cycle the read's memory response arrives.
  - While rd_pend=1, core_req_ack=0.
- Memory side issue:
  - mem_req = ~fifo_empty & (outst_cnt < SCR1_WBUF_OUTST).
  - mem_* fields come from the FIFO head.
  - Pop on mem_req & mem_req_ack; push the head cmd into the tag FIFO (depth SCR1_WBUF_OUTST).
- Memory response (mem_resp != NOTRDY):
  - Pop the tag FIFO.
  - Tag RD: core_resp=mem_resp and core_rdata=mem_rdata combinationally, same cycle, zero added latency.
  - Tag WR: response is absorbed and never reaches the core. RDY_ER sets wbuf_wr_err, which holds until rst.
- outst_cnt:
  - +1 on pop, -1 on response.
  - Pop and response in the same cycle leaves it unchanged.
- Read and write core responses never coincide, because a write is only accepted with rd_pend=0.
- Full: core_req_ack=0; a pop in that cycle frees a slot for the next cycle.
- Empty: mem_req=0; a push in that cycle does not issue in the same cycle.
- wbuf_idle = fifo_empty & (outst_cnt==0).
- A memory response arriving with the tag FIFO empty is a protocol error: ignored; SVA assertion fires.
- rst mid-operation:
  - All buffered writes are discarded.
  - The downstream bridge shares rst, so no stale responses arrive afterwards.
- Width rule: mem_wdata is passed through unmodified; lane steering is done by the bridge.

Optional Feature:
- SCR1_DMEM_WBUF_ERRRESP_EN
  - Defined: while wbuf_wr_err=1, the next read response to the core is forced to RDY_ER regardless of mem_resp, and wbuf_wr_err clears in that cycle. This makes the error precise at the next load.
  - Undefined: read responses pass mem_resp unchanged; wbuf_wr_err is sticky until rst and observable only on the port.

Decomposition:
- Existing package scr1_memif.svh provides type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e.
- Add to scr1_memif.svh: type_scr1_wbuf_entry_s {cmd, width, addr, wdata}.
- Sub-module scr1_wbuf_fifo: parameterised sync FIFO with push/pop/full/empty/cnt, instantiated twice:
  - request FIFO, DEPTH entries;
  - tag FIFO, OUTST entries of 1-bit cmd.

Test Plan:
- Single write 0x100=0xDEADBEEF with mem_req_ack=1 and response 2 cycles later:
  - core_resp=RDY_OK the cycle after acceptance.
  - mem_req the cycle after push with addr 0x100.
  - wbuf_idle returns to 1 after mem RDY_OK.
- Five writes with mem_req_ack=0:
  - Acks for writes 1-4; core_req_ack=0 while the FIFO holds 4.
  - Release mem_req_ack: drains in order 1-4, then write 5 is accepted in the cycle after the first pop.
- Write A, write B, then read C: read accepted immediately but issued after A and B; core_resp=RDY_OK with rdata=mem_rdata only on C's response; no core request acked in between.
- Memory stalls responses with outstanding requests: with mem_req_ack=1 and 3 queued writes, mem_req drops after 2 pops until the first response arrives.
- Posted write gets RDY_ER, then a read gets mem RDY_OK:
  - wbuf_wr_err=1.
  - With SCR1_DMEM_WBUF_ERRRESP_EN: core sees RDY_ER and the flag clears.
  - Without it: core sees RDY_OK and the flag stays 1.
- rst asserted with 3 buffered writes: next cycle wbuf_idle=1, mem_req=0, core_resp=NOTRDY, core_req_ack=1.
